// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state types and constants for the UART program loader
package loader_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
    typedef enum logic [1:0] {HDR_LO, HDR_HI, STREAM} ld_state_t;

    localparam int LOADER_BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - UART byte receiver: rxd synchronizer plus bit FSM (8E1 when LOADER_PARITY_EN)
module uart_rx_core
    import loader_pkg::*;
#(
    parameter int CLK_PER_BIT = 868
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       rx_err
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);

    logic          sync1_q, sync2_q, prev_q;
    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          tick;

    assign tick       = (cnt_q == BIT_LAST);
    assign rx_byte    = shift_q;
    assign byte_valid = valid_q;
    assign rx_err     = err_q;

    // Start needs a real falling edge, so after a bad frame we sit in IDLE until the line recovers.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync2_q) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    state_d   = sync2_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_d     = '0;
                    shift_d   = {sync2_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
`ifdef LOADER_PARITY_EN
                    if (bit_idx_q == 3'd7) state_d = PARITY;
`else
                    if (bit_idx_q == 3'd7) state_d = STOP;
`endif
                end
            end
`ifdef LOADER_PARITY_EN
            PARITY: begin
                if (tick) begin
                    cnt_d = '0;
                    if (sync2_q != ^shift_q) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = STOP;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    if (sync2_q) valid_d = 1'b1;
                    else         err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sync1_q   <= rxd;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: rtl/uart_loader_rx.sv
// rtl/uart_loader_rx.sv - UART program-load front end: word-count header then payload stream (LOADER_PARITY_EN selects 8E1)
module uart_loader_rx
    import loader_pkg::*;
#(
    parameter int CLK_PER_BIT = 868,
    parameter int CNT_WIDTH   = 16
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] loader_data,
    output logic       loader_ready,
    output logic       loader_enable,
    output logic       load_done,
    output logic       frame_err
);

    localparam int BL_W = CNT_WIDTH + 2;

    logic [7:0]           rx_byte;
    logic                 byte_valid, rx_err;
    ld_state_t            state_q, state_d;
    logic [7:0]           hdr_lo_q, hdr_lo_d;
    logic [BL_W-1:0]      bytes_left_q, bytes_left_d;
    logic [7:0]           data_q, data_d;
    logic                 ready_q, ready_d;
    logic                 enable_q, enable_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;
    logic [CNT_WIDTH-1:0] word_cnt;

    uart_rx_core #(.CLK_PER_BIT(CLK_PER_BIT)) u_rx (
        .CLK        (CLK),
        .reset      (reset),
        .rxd        (rxd),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .rx_err     (rx_err)
    );

    assign word_cnt      = CNT_WIDTH'({rx_byte, hdr_lo_q});
    assign loader_data   = data_q;
    assign loader_ready  = ready_q;
    assign loader_enable = enable_q;
    assign load_done     = done_q;
    assign frame_err     = ferr_q;

    always_comb begin
        state_d      = state_q;
        hdr_lo_d     = hdr_lo_q;
        bytes_left_d = bytes_left_q;
        data_d       = data_q;
        ready_d      = 1'b0;
        enable_d     = enable_q;
        done_d       = 1'b0;
        ferr_d       = ferr_q | rx_err;
        // Close the frame on the edge that drops the final loader_ready pulse.
        if (ready_q && bytes_left_q == '0) begin
            enable_d = 1'b0;
            done_d   = 1'b1;
        end
        if (rx_err) begin
            state_d  = HDR_LO;
            enable_d = 1'b0;
        end else if (byte_valid) begin
            case (state_q)
                HDR_LO: begin
                    hdr_lo_d = rx_byte;
                    state_d  = HDR_HI;
                end
                HDR_HI: begin
                    if (word_cnt == '0) begin
                        done_d  = 1'b1;
                        state_d = HDR_LO;
                    end else begin
                        enable_d     = 1'b1;
                        bytes_left_d = BL_W'(word_cnt) * BL_W'(LOADER_BYTES_PER_WORD);
                        state_d      = STREAM;
                    end
                end
                STREAM: begin
                    data_d       = rx_byte;
                    ready_d      = 1'b1;
                    bytes_left_d = bytes_left_q - BL_W'(1);
                    if (bytes_left_q == BL_W'(1)) state_d = HDR_LO;
                end
                default: state_d = HDR_LO;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= HDR_LO;
            hdr_lo_q     <= 8'h00;
            bytes_left_q <= '0;
            data_q       <= 8'h00;
            ready_q      <= 1'b0;
            enable_q     <= 1'b0;
            done_q       <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hdr_lo_q     <= hdr_lo_d;
            bytes_left_q <= bytes_left_d;
            data_q       <= data_d;
            ready_q      <= ready_d;
            enable_q     <= enable_d;
            done_q       <= done_d;
            ferr_q       <= ferr_d;
        end
    end

endmodule
